// File: rtl/cnn_pool_pkg.sv
// Shared types and constants for the 2x2 pooling window feeder.
package cnn_pool_pkg;
  localparam int K          = 2;
  localparam int S          = 2;
  localparam int WIN        = K * S;
  localparam int DATA_WIDTH = 8;

  typedef logic [DATA_WIDTH-1:0] pixel_t;

  localparam int W_TL = 0;
  localparam int W_TR = 1;
  localparam int W_BL = 2;
  localparam int W_BR = 3;

  typedef enum logic [2:0] {
    IDLE,
    FILL_EVEN,
    PAIR_ODD,
    DRAIN,
    DONE
  } feeder_state_e;
endpackage

// File: rtl/pool_window_feeder_if.sv
// Row stream in, 2x2 windows and pipeline controls out to the pooling layer.
interface pool_window_feeder_if
  import cnn_pool_pkg::*;
#(
  parameter int pooling_units = 32,
  parameter int data_width    = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [data_width-1:0] in_data  [2*pooling_units];
  logic [data_width-1:0] win_data [pooling_units][WIN];
  logic                  in_pipe_en;
  logic                  out_pipe_en;
  logic                  ctrl_pool;
  logic                  pool_valid;

  modport master (
    input  in_valid, in_data,
    output in_ready, win_data, in_pipe_en, out_pipe_en, ctrl_pool, pool_valid
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, win_data, in_pipe_en, out_pipe_en, ctrl_pool, pool_valid
  );
endinterface

// File: rtl/pool_window_feeder_line_buf.sv
// Even-row line buffer: one chunk-wide write port, one combinational read port.
module pool_line_buf #(
  parameter int NPX        = 64,
  parameter int DEPTH      = 8,
  parameter int data_width = 8,
  parameter int AW         = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [data_width-1:0] wdata [NPX],
  input  logic [AW-1:0]         raddr,
  output logic [data_width-1:0] rdata [NPX]
);
  logic [data_width-1:0] mem [DEPTH][NPX];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/pool_window_feeder.sv
// Buffers even rows, pairs them with odd rows into 2x2 windows and sequences the pooling pipeline.
module pool_window_feeder
  import cnn_pool_pkg::*;
#(
  parameter int pooling_units = 32,
  parameter int data_width    = 8,
  parameter int MAX_CHUNKS    = 8,
  parameter int ROWP_W        = 8,
  localparam int CHW          = $clog2(MAX_CHUNKS + 1)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic [CHW-1:0]    cfg_chunks,
  input  logic [ROWP_W-1:0] cfg_row_pairs,
  input  logic              cfg_mode,
  output logic              busy,
  output logic              done,
  pool_window_feeder_if.master bus
);
  localparam int NPX = 2 * pooling_units;
  localparam int AW  = (MAX_CHUNKS > 1) ? $clog2(MAX_CHUNKS) : 1;

  feeder_state_e         state_q;
  logic [CHW-1:0]        chunks_q, chunk_q, cfg_chunks_clamped;
  logic [ROWP_W-1:0]     rows_q, row_q, row_inc;
  logic                  busy_q, done_q, in_ready_q, ctrl_pool_q;
  logic                  in_pipe_q, out_pipe_q, pool_valid_q;
  logic [data_width-1:0] win_q    [pooling_units][WIN];
  logic [data_width-1:0] lb_rdata [NPX];
  logic                  xfer, wr_even, pair_odd, last_chunk;

  assign xfer       = bus.in_valid && in_ready_q;
  assign wr_even    = xfer && (state_q == FILL_EVEN);
  assign pair_odd   = xfer && (state_q == PAIR_ODD);
  assign last_chunk = (chunk_q == chunks_q - 1'b1);
  assign row_inc    = row_q + 1'b1;
  assign cfg_chunks_clamped = (cfg_chunks > CHW'(MAX_CHUNKS)) ? CHW'(MAX_CHUNKS) : cfg_chunks;

  pool_line_buf #(
    .NPX(NPX), .DEPTH(MAX_CHUNKS), .data_width(data_width), .AW(AW)
  ) u_line_buf (
    .clk  (clk),
    .we   (wr_even),
    .waddr(chunk_q[AW-1:0]),
    .wdata(bus.in_data),
    .raddr(chunk_q[AW-1:0]),
    .rdata(lb_rdata)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      chunks_q     <= '0;
      chunk_q      <= '0;
      rows_q       <= '0;
      row_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      in_ready_q   <= 1'b0;
      ctrl_pool_q  <= 1'b0;
      in_pipe_q    <= 1'b0;
      out_pipe_q   <= 1'b0;
      pool_valid_q <= 1'b0;
      for (int i = 0; i < pooling_units; i++)
        for (int w = 0; w < WIN; w++)
          win_q[i][w] <= '0;
    end else begin
      done_q       <= 1'b0;
      in_pipe_q    <= pair_odd;
      out_pipe_q   <= in_pipe_q;
      pool_valid_q <= out_pipe_q;
      // Windows are captured on the odd transfer and held until the next one.
      if (pair_odd) begin
        for (int i = 0; i < pooling_units; i++) begin
          win_q[i][W_TL] <= lb_rdata[2*i];
          win_q[i][W_TR] <= lb_rdata[2*i+1];
          win_q[i][W_BL] <= bus.in_data[2*i];
          win_q[i][W_BR] <= bus.in_data[2*i+1];
        end
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            chunks_q    <= cfg_chunks_clamped;
            rows_q      <= cfg_row_pairs;
            ctrl_pool_q <= cfg_mode;
            busy_q      <= 1'b1;
            chunk_q     <= '0;
            row_q       <= '0;
            if (cfg_chunks == '0 || cfg_row_pairs == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q    <= FILL_EVEN;
              in_ready_q <= 1'b1;
            end
          end
        end
        FILL_EVEN: begin
          if (wr_even) begin
            if (last_chunk) begin
              chunk_q <= '0;
              state_q <= PAIR_ODD;
            end else begin
              chunk_q <= chunk_q + 1'b1;
            end
          end
        end
        PAIR_ODD: begin
          if (pair_odd) begin
            if (last_chunk) begin
              chunk_q <= '0;
              row_q   <= row_inc;
              if (row_inc == rows_q) begin
                state_q    <= DRAIN;
                in_ready_q <= 1'b0;
              end else begin
                state_q <= FILL_EVEN;
              end
            end else begin
              chunk_q <= chunk_q + 1'b1;
            end
          end
        end
        // Leaving once in_pipe has cleared lines done up with the last pool_valid.
        DRAIN: begin
          if (!in_pipe_q) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q    <= IDLE;
          busy_q     <= 1'b0;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign bus.in_ready    = in_ready_q;
  assign bus.win_data    = win_q;
  assign bus.in_pipe_en  = in_pipe_q;
  assign bus.out_pipe_en = out_pipe_q;
  assign bus.pool_valid  = pool_valid_q;
  assign bus.ctrl_pool   = ctrl_pool_q;
endmodule
